load_store_unit: RTL and testbench

Memory-stage block directly downstream of the ALU. Takes the ALU result as the effective address plus store data and the load/store size code. Drives a single-port data-memory bus with byte enables through a request/ready handshake and returns aligned, sign- or zero-extended load data to writeback. It stalls the pipeline while an access is outstanding and flags misaligned, illegal and timed-out accesses.

---
 rtl/load_store_unit_if.sv | 24 ++
 rtl/load_store_unit.sv | 163 ++++++++++++++++
 tb/tb_load_store_unit.sv | 395 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/load_store_unit_if.sv
// Data-memory bus between the load/store unit (master) and a single-port memory (slave).
// Latency: none, wires only.
// Backpressure: the memory stretches an access by holding mem_ready_i low.
interface load_store_unit_if #(
    parameter int DATA_WIDTH = 32
);
    logic                    mem_req_o;
    logic                    mem_we_o;
    logic [DATA_WIDTH-1:0]   mem_addr_o;
    logic [DATA_WIDTH/8-1:0] mem_be_o;
    logic [DATA_WIDTH-1:0]   mem_wdata_o;
    logic                    mem_ready_i;
    logic [DATA_WIDTH-1:0]   mem_rdata_i;

    modport master (
        output mem_req_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o,
        input  mem_ready_i, mem_rdata_i
    );

    modport slave (
        input  mem_req_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o,
        output mem_ready_i, mem_rdata_i
    );
endinterface

// File: rtl/load_store_unit.sv
// Memory stage: turns ALU address + store data into a byte-enabled bus access, returns extended load data.
// Latency: 2 cycles accept-to-response with zero wait states; 1 cycle for misaligned/illegal requests.
// Backpressure: req_ready_o low (busy_o high) while an access is outstanding; memory stalls via mem_ready_i.
module load_store_unit #(
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  is_load_i,
    input  logic                  is_store_i,
    input  logic [2:0]            funct3_i,
    input  logic [DATA_WIDTH-1:0] addr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    output logic                  busy_o,
    output logic                  rsp_valid_o,
    output logic [DATA_WIDTH-1:0] rsp_data_o,
    output logic [1:0]            rsp_err_o,
    load_store_unit_if.master     bus
);
    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    // Count value at which the next ready-less ACCESS cycle is the last one allowed.
    localparam logic [CW-1:0] TO_LAST = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    typedef enum logic {IDLE, ACCESS} state_t;
    state_t state, state_nxt;

    logic [CW-1:0]  to_cnt;
    logic [1:0]     lat_off;
    logic [1:0]     lat_size;
    logic           lat_uns;
    logic           lat_load;

    logic           mem_req_q, mem_we_q;
    logic [31:0]    mem_addr_q, mem_wdata_q;
    logic [3:0]     mem_be_q;

    logic           accept, req_err, legal_acc, err_acc, done, timeout;
    logic [3:0]     be_nxt;
    logic [31:0]    wdata_nxt;
    logic [7:0]     lane_b;
    logic [15:0]    lane_h;
    logic [31:0]    load_val;

    assign req_ready_o = (state == IDLE);
    assign busy_o      = (state == ACCESS);

    // A request with neither type bit set is not a memory op and is dropped silently.
    assign accept  = req_valid_i & req_ready_o & (is_load_i | is_store_i);
    assign req_err = (is_load_i & is_store_i)
                   | (funct3_i == 3'b011) | (funct3_i[2:1] == 2'b11)
                   | (is_store_i & funct3_i[2])
                   | ((funct3_i[1:0] == 2'b01) & addr_i[0])
                   | ((funct3_i[1:0] == 2'b10) & (addr_i[1:0] != 2'b00));
    assign legal_acc = accept & ~req_err;
    assign err_acc   = accept & req_err;
    assign done      = (state == ACCESS) & bus.mem_ready_i;
    assign timeout   = (TIMEOUT_CYCLES != 0) & (state == ACCESS) & ~bus.mem_ready_i & (to_cnt == TO_LAST);

    assign bus.mem_req_o   = mem_req_q;
    assign bus.mem_we_o    = mem_we_q;
    assign bus.mem_addr_o  = mem_addr_q;
    assign bus.mem_be_o    = mem_be_q;
    assign bus.mem_wdata_o = mem_wdata_q;

    // Byte-lane enables and lane-replicated write data for the incoming request.
    always_comb begin
        be_nxt    = 4'b1111;
        wdata_nxt = wdata_i;
        case (funct3_i[1:0])
            2'b00: begin
                be_nxt    = 4'b0001 << addr_i[1:0];
                wdata_nxt = {4{wdata_i[7:0]}};
            end
            2'b01: begin
                be_nxt    = addr_i[1] ? 4'b1100 : 4'b0011;
                wdata_nxt = {2{wdata_i[15:0]}};
            end
            default: ;
        endcase
    end

    // Pick the addressed lane out of the read word and sign/zero extend it.
    always_comb begin
        case (lat_off)
            2'd0:    lane_b = bus.mem_rdata_i[7:0];
            2'd1:    lane_b = bus.mem_rdata_i[15:8];
            2'd2:    lane_b = bus.mem_rdata_i[23:16];
            default: lane_b = bus.mem_rdata_i[31:24];
        endcase
        lane_h = lat_off[1] ? bus.mem_rdata_i[31:16] : bus.mem_rdata_i[15:0];
        case (lat_size)
            2'b00:   load_val = {{24{~lat_uns & lane_b[7]}}, lane_b};
            2'b01:   load_val = {{16{~lat_uns & lane_h[15]}}, lane_h};
            default: load_val = bus.mem_rdata_i;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next state: enter ACCESS on a legal request, leave on completion or timeout.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (legal_acc)        state_nxt = ACCESS;
            ACCESS:  if (done || timeout)  state_nxt = IDLE;
            default:                       state_nxt = IDLE;
        endcase
    end

    // Wait-state counter; restarts with every new access.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                      to_cnt <= '0;
        else if (legal_acc)                              to_cnt <= '0;
        else if ((state == ACCESS) && !bus.mem_ready_i)  to_cnt <= to_cnt + 1'b1;
    end

    // Bus drive and load-return context, captured at accept and held for the whole access.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_be_q    <= '0;
            mem_wdata_q <= '0;
            lat_off     <= '0;
            lat_size    <= '0;
            lat_uns     <= 1'b0;
            lat_load    <= 1'b0;
        end else if (legal_acc) begin
            mem_req_q   <= 1'b1;
            mem_we_q    <= is_store_i;
            mem_addr_q  <= {addr_i[31:2], 2'b00};
            mem_be_q    <= be_nxt;
            mem_wdata_q <= wdata_nxt;
            lat_off     <= addr_i[1:0];
            lat_size    <= funct3_i[1:0];
            lat_uns     <= funct3_i[2];
            lat_load    <= is_load_i;
        end else if (done || timeout) begin
            mem_req_q   <= 1'b0;
        end
    end

    // One-cycle response pulse for completion, timeout or rejected request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid_o <= 1'b0;
            rsp_err_o   <= 2'b00;
            rsp_data_o  <= '0;
        end else begin
            rsp_valid_o <= err_acc | done | timeout;
            rsp_err_o   <= err_acc ? 2'b01 : (timeout ? 2'b10 : 2'b00);
            rsp_data_o  <= (done && lat_load) ? load_val : '0;
        end
    end
endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed cases plus randomized ops against a byte-level memory model.
// Latency: n/a.
// Backpressure: the bench plays the memory and inserts programmable wait states.
module tb_load_store_unit;
    localparam int TO = 16;

    logic        clk;
    logic        rst_n;
    logic        req_valid_i, req_ready_o, is_load_i, is_store_i;
    logic [2:0]  funct3_i;
    logic [31:0] addr_i, wdata_i;
    logic        busy_o, rsp_valid_o;
    logic [31:0] rsp_data_o;
    logic [1:0]  rsp_err_o;

    int checks = 0;
    int errors = 0;

    load_store_unit_if bus();

    load_store_unit #(.DATA_WIDTH(32), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .is_load_i(is_load_i), .is_store_i(is_store_i), .funct3_i(funct3_i),
        .addr_i(addr_i), .wdata_i(wdata_i),
        .busy_o(busy_o), .rsp_valid_o(rsp_valid_o), .rsp_data_o(rsp_data_o), .rsp_err_o(rsp_err_o),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory seen by the bus (word array) and the reference byte memory.
    logic [31:0] bus_mem [0:1023];
    logic [7:0]  mdl_mem [0:4095];

    typedef struct {
        bit          got;
        logic [31:0] data;
        logic [1:0]  err;
        int          lat;
        int          req_cyc;
        int          busy_cyc;
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wd;
        bit          stable;
        bit          rdy_ok;
    } obs_t;

    function automatic int op_bytes(input logic [2:0] f3);
        return 1 << f3[1:0];
    endfunction

    function automatic logic [1:0] mdl_err(input logic ld, input logic st, input logic [2:0] f3, input logic [31:0] a);
        if (ld && st) return 2'b01;
        if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) return 2'b01;
        if (st && f3[2]) return 2'b01;
        if ((int'(a[1:0]) % op_bytes(f3)) != 0) return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic [3:0] mdl_be(input logic [2:0] f3, input logic [31:0] a);
        logic [3:0] r = '0;
        for (int i = 0; i < op_bytes(f3); i++) r[int'(a[1:0]) + i] = 1'b1;
        return r;
    endfunction

    function automatic logic [31:0] mdl_wdata(input logic [2:0] f3, input logic [31:0] wd);
        logic [31:0] r = '0;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % op_bytes(f3)) +: 8];
        return r;
    endfunction

    function automatic logic [31:0] mdl_load(input logic [2:0] f3, input logic [31:0] a);
        int          n = op_bytes(f3);
        logic [31:0] v = '0;
        for (int i = 0; i < n; i++) v = v | (32'(mdl_mem[int'(a[11:0]) + i]) << (8 * i));
        if (!f3[2] && n < 4 && v[8*n-1]) v = v | ~((32'd1 << (8 * n)) - 32'd1);
        return v;
    endfunction

    task automatic mdl_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
        for (int i = 0; i < op_bytes(f3); i++) mdl_mem[int'(a[11:0]) + i] = wd[8*i +: 8];
    endtask

    task automatic preload(input logic [31:0] a, input logic [31:0] v);
        bus_mem[a[11:2]] = v;
        for (int i = 0; i < 4; i++) mdl_mem[int'(a[11:0]) + i] = v[8*i +: 8];
    endtask

    // Issue one request at the current negedge, play the memory, return at the negedge of the response.
    // waits < 0 means the memory never answers.
    task automatic run_op(input logic ld, input logic st, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] wd, input int waits, output obs_t o);
        o.got = 0; o.data = '0; o.err = '0; o.lat = 0; o.req_cyc = 0; o.busy_cyc = 0;
        o.we = 0; o.addr = '0; o.be = '0; o.wd = '0; o.stable = 1;
        o.rdy_ok = (req_ready_o === 1'b1);
        req_valid_i = 1'b1; is_load_i = ld; is_store_i = st; funct3_i = f3; addr_i = a; wdata_i = wd;
        for (int cyc = 1; cyc <= 60; cyc++) begin
            @(negedge clk);
            req_valid_i = 1'b0;
            is_load_i = 1'($urandom); is_store_i = 1'($urandom); addr_i = $urandom; wdata_i = $urandom;
            bus.mem_ready_i = 1'b0;
            bus.mem_rdata_i = $urandom;
            if (rsp_valid_o === 1'b1) begin
                o.got = 1; o.data = rsp_data_o; o.err = rsp_err_o; o.lat = cyc;
                break;
            end
            if (busy_o === 1'b1) o.busy_cyc++;
            if (bus.mem_req_o === 1'b1) begin
                if (o.req_cyc == 0) begin
                    o.we = bus.mem_we_o; o.addr = bus.mem_addr_o; o.be = bus.mem_be_o; o.wd = bus.mem_wdata_o;
                end else if (o.we !== bus.mem_we_o || o.addr !== bus.mem_addr_o ||
                             o.be !== bus.mem_be_o || o.wd !== bus.mem_wdata_o) begin
                    o.stable = 0;
                end
                o.req_cyc++;
                if (waits >= 0 && o.req_cyc == waits + 1) begin
                    bus.mem_ready_i = 1'b1;
                    if (bus.mem_we_o === 1'b1) begin
                        for (int i = 0; i < 4; i++)
                            if (bus.mem_be_o[i]) bus_mem[bus.mem_addr_o[11:2]][8*i +: 8] = bus.mem_wdata_o[8*i +: 8];
                    end else begin
                        bus.mem_rdata_i = bus_mem[bus.mem_addr_o[11:2]];
                    end
                end
            end
        end
        is_load_i = 1'b0; is_store_i = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if ({req_ready_o, busy_o, rsp_valid_o, rsp_err_o, bus.mem_req_o, bus.mem_we_o, bus.mem_be_o} !== 11'b100_00_00_0000) begin
            errors++;
            $display("FAIL reset_ctrl: got rdy/busy/vld/err/req/we/be=%b expected 10000000000",
                     {req_ready_o, busy_o, rsp_valid_o, rsp_err_o, bus.mem_req_o, bus.mem_we_o, bus.mem_be_o});
        end
        checks++;
        if ({rsp_data_o, bus.mem_addr_o, bus.mem_wdata_o} !== 96'd0) begin
            errors++;
            $display("FAIL reset_data: got data=%h addr=%h wdata=%h expected all 0", rsp_data_o, bus.mem_addr_o, bus.mem_wdata_o);
        end
    endtask

    task automatic test_word();
        obs_t o;
        run_op(1'b0, 1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 0, o);
        mdl_store(3'b010, 32'h100, 32'hDEADBEEF);
        checks++;
        if (!o.rdy_ok || !o.got || o.err !== 2'b00 || o.lat != 2 || o.data !== 32'h0) begin
            errors++;
            $display("FAIL sw_rsp: rdy=%0d got=%0d err=%b lat=%0d data=%h expected 1 1 00 2 00000000", o.rdy_ok, o.got, o.err, o.lat, o.data);
        end
        checks++;
        if (o.we !== 1'b1 || o.addr !== 32'h100 || o.be !== 4'b1111 || o.wd !== 32'hDEADBEEF || o.req_cyc != 1) begin
            errors++;
            $display("FAIL sw_bus: we=%b addr=%h be=%b wd=%h req_cyc=%0d expected 1 00000100 1111 deadbeef 1", o.we, o.addr, o.be, o.wd, o.req_cyc);
        end
        run_op(1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 0, o);
        checks++;
        if (!o.got || o.err !== 2'b00 || o.lat != 2 || o.data !== 32'hDEADBEEF || o.we !== 1'b0) begin
            errors++;
            $display("FAIL lw_rsp: got=%0d err=%b lat=%0d data=%h we=%b expected 1 00 2 deadbeef 0", o.got, o.err, o.lat, o.data, o.we);
        end
    endtask

    task automatic test_extension();
        obs_t        o;
        logic [2:0]  f3s  [5];
        logic [31:0] adrs [5];
        logic [31:0] exps [5];
        f3s  = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b000};
        adrs = '{32'h203, 32'h203, 32'h202, 32'h200, 32'h201};
        exps = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF80F1, 32'h00007F00, 32'h0000007F};
        preload(32'h200, 32'h80F17F00);
        for (int i = 0; i < 5; i++) begin
            run_op(1'b1, 1'b0, f3s[i], adrs[i], 32'h0, i % 3, o);
            checks++;
            if (!o.got || o.err !== 2'b00 || o.data !== exps[i] || o.addr !== 32'h200 || o.be !== mdl_be(f3s[i], adrs[i])) begin
                errors++;
                $display("FAIL ext_%0d: got=%0d err=%b data=%h addr=%h be=%b expected 1 00 %h 00000200 %b",
                         i, o.got, o.err, o.data, o.addr, o.be, exps[i], mdl_be(f3s[i], adrs[i]));
            end
        end
    endtask

    task automatic test_substore();
        obs_t o;
        run_op(1'b0, 1'b1, 3'b000, 32'h301, 32'h12345678, 0, o);
        mdl_store(3'b000, 32'h301, 32'h12345678);
        checks++;
        if (!o.got || o.err !== 2'b00 || o.be !== 4'b0010 || o.wd !== 32'h78787878 || o.addr !== 32'h300) begin
            errors++;
            $display("FAIL sb: got=%0d err=%b be=%b wd=%h addr=%h expected 1 00 0010 78787878 00000300", o.got, o.err, o.be, o.wd, o.addr);
        end
        run_op(1'b0, 1'b1, 3'b001, 32'h302, 32'h12345678, 1, o);
        mdl_store(3'b001, 32'h302, 32'h12345678);
        checks++;
        if (!o.got || o.err !== 2'b00 || o.be !== 4'b1100 || o.wd !== 32'h56785678 || o.lat != 3) begin
            errors++;
            $display("FAIL sh: got=%0d err=%b be=%b wd=%h lat=%0d expected 1 00 1100 56785678 3", o.got, o.err, o.be, o.wd, o.lat);
        end
        run_op(1'b1, 1'b0, 3'b010, 32'h300, 32'h0, 0, o);
        checks++;
        if (o.data !== 32'h56787800) begin
            errors++;
            $display("FAIL sub_readback: got %h expected 56787800", o.data);
        end
    endtask

    task automatic test_errors();
        obs_t       o;
        logic       lds [5];
        logic       sts [5];
        logic [2:0] f3s [5];
        logic [31:0] ads [5];
        bit         quiet;
        lds = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        sts = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        f3s = '{3'b010, 3'b001, 3'b110, 3'b010, 3'b100};
        ads = '{32'h102, 32'h101, 32'h100, 32'h100, 32'h100};
        for (int i = 0; i < 5; i++) begin
            run_op(lds[i], sts[i], f3s[i], ads[i], 32'hFFFFFFFF, 0, o);
            checks++;
            if (!o.got || o.err !== 2'b01 || o.lat != 1 || o.data !== 32'h0 || o.req_cyc != 0) begin
                errors++;
                $display("FAIL err_%0d: got=%0d err=%b lat=%0d data=%h req_cyc=%0d expected 1 01 1 00000000 0",
                         i, o.got, o.err, o.lat, o.data, o.req_cyc);
            end
        end
        // A request without a type bit produces nothing.
        req_valid_i = 1'b1; is_load_i = 1'b0; is_store_i = 1'b0; funct3_i = 3'b010; addr_i = 32'h100;
        quiet = 1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            req_valid_i = 1'b0;
            if (rsp_valid_o !== 1'b0 || bus.mem_req_o !== 1'b0 || req_ready_o !== 1'b1) quiet = 0;
        end
        checks++;
        if (!quiet) begin
            errors++;
            $display("FAIL no_type: got activity on a typeless request, expected none");
        end
    endtask

    task automatic test_wait_timeout();
        obs_t o;
        bit   quiet;
        run_op(1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 5, o);
        checks++;
        if (!o.got || o.data !== 32'hDEADBEEF || o.busy_cyc != 6 || o.req_cyc != 6 || o.lat != 7 || !o.stable) begin
            errors++;
            $display("FAIL wait5: got=%0d data=%h busy=%0d req=%0d lat=%0d stable=%0d expected 1 deadbeef 6 6 7 1",
                     o.got, o.data, o.busy_cyc, o.req_cyc, o.lat, o.stable);
        end
        run_op(1'b1, 1'b0, 3'b010, 32'h100, 32'h0, -1, o);
        checks++;
        if (!o.got || o.err !== 2'b10 || o.data !== 32'h0 || o.req_cyc != TO || o.busy_cyc != TO || o.lat != TO + 1) begin
            errors++;
            $display("FAIL timeout: got=%0d err=%b data=%h req=%0d busy=%0d lat=%0d expected 1 10 00000000 %0d %0d %0d",
                     o.got, o.err, o.data, o.req_cyc, o.busy_cyc, o.lat, TO, TO, TO + 1);
        end
        // Late ready while idle must be ignored.
        bus.mem_ready_i = 1'b1;
        bus.mem_rdata_i = 32'hCAFEF00D;
        quiet = 1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            bus.mem_ready_i = 1'b0;
            if (rsp_valid_o !== 1'b0 || bus.mem_req_o !== 1'b0 || req_ready_o !== 1'b1) quiet = 0;
        end
        checks++;
        if (!quiet) begin
            errors++;
            $display("FAIL late_ready: got a response or bus activity, expected none");
        end
    endtask

    task automatic test_back_to_back();
        obs_t o1, o2;
        run_op(1'b0, 1'b1, 3'b010, 32'h180, 32'h0BADF00D, 0, o1);
        mdl_store(3'b010, 32'h180, 32'h0BADF00D);
        run_op(1'b1, 1'b0, 3'b010, 32'h180, 32'h0, 0, o2);
        checks++;
        if (!o2.rdy_ok || !o2.got || o2.lat != 2 || o2.data !== 32'h0BADF00D || o2.req_cyc != 1) begin
            errors++;
            $display("FAIL b2b: rdy=%0d got=%0d lat=%0d data=%h req=%0d expected 1 1 2 0badf00d 1",
                     o2.rdy_ok, o2.got, o2.lat, o2.data, o2.req_cyc);
        end
    endtask

    task automatic test_reset_mid_access();
        bit quiet;
        req_valid_i = 1'b1; is_load_i = 1'b1; is_store_i = 1'b0; funct3_i = 3'b010; addr_i = 32'h100;
        @(negedge clk);
        req_valid_i = 1'b0; is_load_i = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.mem_req_o !== 1'b1 || busy_o !== 1'b1) begin
            errors++;
            $display("FAIL rst_pre: req=%b busy=%b expected 1 1", bus.mem_req_o, busy_o);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.mem_req_o !== 1'b0 || req_ready_o !== 1'b1 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL rst_async: req=%b rdy=%b busy=%b expected 0 1 0", bus.mem_req_o, req_ready_o, busy_o);
        end
        @(negedge clk);
        rst_n = 1'b1;
        quiet = 1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (rsp_valid_o !== 1'b0 || bus.mem_req_o !== 1'b0 || req_ready_o !== 1'b1) quiet = 0;
        end
        checks++;
        if (!quiet) begin
            errors++;
            $display("FAIL rst_after: saw response or bus activity after mid-access reset");
        end
    endtask

    task automatic test_random();
        obs_t        o;
        logic        ld, st;
        logic [2:0]  f3;
        logic [31:0] a, wd, ed;
        logic [1:0]  ee;
        int          w, sel;
        for (int i = 0; i < 16; i++) preload(32'h400 + 32'(4 * i), $urandom);
        for (int n = 0; n < 80; n++) begin
            sel = $urandom_range(0, 9);
            ld  = (sel <= 4);
            st  = (sel == 0) || (sel >= 5);
            f3  = 3'($urandom_range(0, 7));
            a   = 32'h400 + 32'($urandom_range(0, 60));
            wd  = $urandom;
            w   = $urandom_range(0, 3);
            ee  = mdl_err(ld, st, f3, a);
            ed  = (ee == 2'b00 && ld) ? mdl_load(f3, a) : 32'h0;
            run_op(ld, st, f3, a, wd, w, o);
            checks++;
            if (!o.got || o.err !== ee || o.data !== ed) begin
                errors++;
                $display("FAIL rnd_rsp[%0d] ld=%b st=%b f3=%b a=%h: got=%0d err=%b data=%h expected 1 %b %h",
                         n, ld, st, f3, a, o.got, o.err, o.data, ee, ed);
            end
            if (ee == 2'b00) begin
                checks++;
                if (o.lat != w + 2 || o.req_cyc != w + 1 || o.addr !== {a[31:2], 2'b00} || o.be !== mdl_be(f3, a) ||
                    o.we !== st || !o.stable || (st && o.wd !== mdl_wdata(f3, wd))) begin
                    errors++;
                    $display("FAIL rnd_bus[%0d]: lat=%0d req=%0d addr=%h be=%b we=%b wd=%h stable=%0d expected %0d %0d %h %b %b %h 1",
                             n, o.lat, o.req_cyc, o.addr, o.be, o.we, o.wd, o.stable,
                             w + 2, w + 1, {a[31:2], 2'b00}, mdl_be(f3, a), st, mdl_wdata(f3, wd));
                end
                if (st) mdl_store(f3, a, wd);
            end else begin
                checks++;
                if (o.lat != 1 || o.req_cyc != 0) begin
                    errors++;
                    $display("FAIL rnd_err[%0d]: lat=%0d req=%0d expected 1 0", n, o.lat, o.req_cyc);
                end
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) bus_mem[i] = '0;
        for (int i = 0; i < 4096; i++) mdl_mem[i] = '0;
        rst_n = 1'b0;
        req_valid_i = 1'b0; is_load_i = 1'b0; is_store_i = 1'b0; funct3_i = '0; addr_i = '0; wdata_i = '0;
        bus.mem_ready_i = 1'b0; bus.mem_rdata_i = '0;
        repeat (3) @(negedge clk);
        test_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        test_word();
        test_extension();
        test_substore();
        test_errors();
        test_wait_timeout();
        test_back_to_back();
        test_reset_mid_access();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
